// File: rtl/rgb_pwm_pkg.sv
// Shared constants and types for the RGB PWM driver.
//   PWM_W          default PWM counter / duty width
//   R_*, G_*, B_*  bit positions of each colour component in the 24-bit code
//   duty_t         one colour component / duty value at the default width
package rgb_pwm_pkg;

  localparam int PWM_W = 8;

  localparam int R_HI = 23;
  localparam int R_LO = 16;
  localparam int G_HI = 15;
  localparam int G_LO = 8;
  localparam int B_HI = 7;
  localparam int B_LO = 0;

  typedef logic [PWM_W-1:0] duty_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM colour channel: pending register, duty register and registered
// compare output.
//   clk, rst_n   clock and synchronous active-low reset
//   enable       PWM running; when low, duty tracks the latest colour
//   load, din    capture strobe and colour value for this channel
//   boundary     last tick of a PWM period; duty is updated here
//   pwm_cnt      shared PWM counter from the top level
//   led          registered output, high while pwm_cnt < duty
// Build option: RGB_PWM_FADE_EN makes duty step by 1 per period toward
// the loaded colour instead of jumping to it.
module pwm_channel #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             load,
  input  logic             boundary,
  input  logic [PWM_W-1:0] din,
  input  logic [PWM_W-1:0] pwm_cnt,
  output logic             led
);
  import rgb_pwm_pkg::*;

  logic [PWM_W-1:0] pending;
  logic [PWM_W-1:0] duty;
  logic [PWM_W-1:0] target;
  logic [PWM_W-1:0] duty_at_boundary;

  // A load in the same cycle bypasses the pending register.
  assign target = load ? din : pending;

`ifdef RGB_PWM_FADE_EN
  always_comb begin
    duty_at_boundary = duty;
    if (duty < target) begin
      duty_at_boundary = duty + 1'b1;
    end else if (duty > target) begin
      duty_at_boundary = duty - 1'b1;
    end
  end
`else
  assign duty_at_boundary = target;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
      duty    <= '0;
      led     <= 1'b0;
    end else begin
      if (load) begin
        pending <= din;
      end
      // While stopped the duty follows the colour directly, so a restart
      // begins with the newest value rather than a fade.
      if (!enable) begin
        duty <= target;
      end else if (boundary) begin
        duty <= duty_at_boundary;
      end
      led <= enable && (pwm_cnt < duty);
    end
  end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM driver for a common RGB LED. Colours are captured on
// load and applied only at PWM period boundaries, so outputs never glitch
// mid-period.
//   clk, rst_n            clock and synchronous active-low reset
//   rgb[23:0], load       colour code (R=[23:16], G=[15:8], B=[7:0]) and strobe
//   enable                runs the PWM when high
//   led_r, led_g, led_b   registered PWM outputs, active-high
//   period_start          one-cycle pulse with the first outputs of each period
// Build option: RGB_PWM_FADE_EN (see pwm_channel) enables per-period fading.
module rgb_pwm_driver #(
  parameter int PRESCALE = 4,
  parameter int PWM_W    = rgb_pwm_pkg::PWM_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] rgb,
  input  logic        load,
  input  logic        enable,
  output logic        led_r,
  output logic        led_g,
  output logic        led_b,
  output logic        period_start
);
  import rgb_pwm_pkg::*;

  localparam int              PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic [PWM_W-1:0] pwm_cnt;
  logic             tick;
  logic             boundary;
  duty_t            col_r;
  duty_t            col_g;
  duty_t            col_b;

  assign tick     = enable && (pre_cnt == PRE_MAX);
  assign boundary = tick && (pwm_cnt == {PWM_W{1'b1}});

  assign col_r = rgb[R_HI:R_LO];
  assign col_g = rgb[G_HI:G_LO];
  assign col_b = rgb[B_HI:B_LO];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt      <= '0;
      pwm_cnt      <= '0;
      period_start <= 1'b0;
    end else if (!enable) begin
      pre_cnt      <= '0;
      pwm_cnt      <= '0;
      period_start <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
      // Counter state 0/0 is seen exactly once per period, including the
      // first enabled cycle after a restart; the pulse lines up with the
      // outputs produced from that state.
      period_start <= (pwm_cnt == '0) && (pre_cnt == '0);
    end
  end

  pwm_channel #(.PWM_W(PWM_W)) u_ch_r (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .load     (load),
    .boundary (boundary),
    .din      (PWM_W'(col_r)),
    .pwm_cnt  (pwm_cnt),
    .led      (led_r)
  );

  pwm_channel #(.PWM_W(PWM_W)) u_ch_g (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .load     (load),
    .boundary (boundary),
    .din      (PWM_W'(col_g)),
    .pwm_cnt  (pwm_cnt),
    .led      (led_g)
  );

  pwm_channel #(.PWM_W(PWM_W)) u_ch_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .load     (load),
    .boundary (boundary),
    .din      (PWM_W'(col_b)),
    .pwm_cnt  (pwm_cnt),
    .led      (led_b)
  );

endmodule
